// File: rtl/sram_1rw1r_param_model_if.sv
// Signal bundle for the 1RW + 1R SRAM model: port 0 read/write, port 1 read-only,
// plus the busy and collision status flags.
interface sram_1rw1r_param_model_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int WMASK_WIDTH    = 8,
    parameter int NUM_SPARE_COLS = 1,
    parameter int ADDR_WIDTH     = 6
);
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
    localparam int WORD_WIDTH = DATA_WIDTH + NUM_SPARE_COLS;

    logic                      csb0;
    logic                      web0;
    logic [NUM_WMASKS-1:0]     wmask0;
    logic [NUM_SPARE_COLS-1:0] spare_wen0;
    logic [ADDR_WIDTH-1:0]     addr0;
    logic [WORD_WIDTH-1:0]     din0;
    logic [WORD_WIDTH-1:0]     dout0;
    logic                      csb1;
    logic [ADDR_WIDTH-1:0]     addr1;
    logic [WORD_WIDTH-1:0]     dout1;
    logic                      busy;
    logic                      collision;

    modport master (
        output csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
        input  dout0, dout1, busy, collision
    );

    modport slave (
        input  csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
        output dout0, dout1, busy, collision
    );
endinterface

// File: rtl/sram_1rw1r_param_model.sv
// Flop-based 1RW + 1R SRAM model with lane/spare write masks, an optional
// post-reset initialisation sweep and a same-address write/read collision flag.
module sram_1rw1r_param_model #(
    parameter int DATA_WIDTH     = 32,
    parameter int WMASK_WIDTH    = 8,
    parameter int NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH,
    parameter int NUM_SPARE_COLS = 1,
    parameter int ADDR_WIDTH     = 6,
    parameter int WORD_WIDTH     = DATA_WIDTH + NUM_SPARE_COLS,
    parameter int INIT_ON_RESET  = 1,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic clk0,
    input  logic rstb0,
    sram_1rw1r_param_model_if.slave bus
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SWEEP_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [WORD_WIDTH-1:0] mem [RAM_DEPTH];
    logic [WORD_WIDTH-1:0] wbe;
    logic                  ready;
    logic                  user_wr;

    assign ready    = (state == ST_READY);
    assign user_wr  = ready && !bus.csb0 && !bus.web0;
    assign bus.busy = !ready;

    // Expand the lane mask and spare-column enables into a per-bit write enable.
    always_comb begin
        wbe = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            wbe[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{bus.wmask0[i]}};
        end
        for (int j = 0; j < NUM_SPARE_COLS; j++) begin
            wbe[DATA_WIDTH+j] = bus.spare_wen0[j];
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == SWEEP_LAST) begin
                state <= ST_READY;
            end
        end
    end

    // The array itself is never reset; only the sweep clears it.
    always_ff @(posedge clk0) begin
        if (state == ST_INIT) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (user_wr) begin
            mem[bus.addr0] <= (mem[bus.addr0] & ~wbe) | (bus.din0 & wbe);
        end
    end

    // Reads sample the array before this edge's write lands, so a colliding
    // port 1 read returns the old word.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            bus.dout0     <= '0;
            bus.dout1     <= '0;
            bus.collision <= 1'b0;
        end else if (!ready) begin
            bus.dout0     <= '0;
            bus.dout1     <= '0;
            bus.collision <= 1'b0;
        end else begin
            if (!bus.csb0 && bus.web0) begin
                bus.dout0 <= mem[bus.addr0];
            end
            if (!bus.csb1) begin
                bus.dout1 <= mem[bus.addr1];
            end
            bus.collision <= user_wr && !bus.csb1 && (bus.addr0 == bus.addr1);
        end
    end
endmodule

// File: tb/tb_sram_1rw1r_param_model.sv
// Self-checking bench for sram_1rw1r_param_model: directed init/mask/collision/hold/reset
// scenarios plus randomized traffic checked against an array-based reference model.
module tb_sram_1rw1r_param_model;
    localparam int DW    = 32;
    localparam int MW    = 8;
    localparam int NM    = DW / MW;
    localparam int SC    = 1;
    localparam int AW    = 6;
    localparam int WW    = DW + SC;
    localparam int DEPTH = 1 << AW;

    logic clk0;
    logic rstb0;
    logic rstbB;
    int   testsRun;
    int   testsFailed;
    int   busyLen;

    logic [WW-1:0] modelMem [DEPTH];
    logic [WW-1:0] expDout0;
    logic [WW-1:0] expDout1;
    logic          expCollision;
    logic [63:0]   rnd;

    sram_1rw1r_param_model_if #(.DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_SPARE_COLS(SC), .ADDR_WIDTH(AW)) bus ();
    sram_1rw1r_param_model_if #(.DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_SPARE_COLS(SC), .ADDR_WIDTH(AW)) busB ();

    sram_1rw1r_param_model #(
        .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_SPARE_COLS(SC), .ADDR_WIDTH(AW),
        .INIT_ON_RESET(1), .INIT_VALUE(33'h0)
    ) dut (
        .clk0(clk0), .rstb0(rstb0), .bus(bus)
    );

    sram_1rw1r_param_model #(
        .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .NUM_SPARE_COLS(SC), .ADDR_WIDTH(AW),
        .INIT_ON_RESET(0), .INIT_VALUE(33'h0)
    ) dutB (
        .clk0(clk0), .rstb0(rstbB), .bus(busB)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic driveIdle();
        bus.csb0 = 1'b1;  bus.web0 = 1'b1;  bus.wmask0 = '0;  bus.spare_wen0 = '0;
        bus.addr0 = '0;   bus.din0 = '0;    bus.csb1 = 1'b1;  bus.addr1 = '0;
        busB.csb0 = 1'b1; busB.web0 = 1'b1; busB.wmask0 = '0; busB.spare_wen0 = '0;
        busB.addr0 = '0;  busB.din0 = '0;   busB.csb1 = 1'b1; busB.addr1 = '0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        expDout0 = '0;
        expDout1 = '0;
        expCollision = 1'b0;
    endtask

    // Drive one cycle of traffic on the main instance (called at a negedge),
    // advance the reference model at the edge and check all outputs afterwards.
    task automatic applyStimulus(input logic c0, input logic w0, input logic [NM-1:0] m,
                                 input logic [SC-1:0] s, input logic [AW-1:0] a0,
                                 input logic [WW-1:0] d, input logic c1, input logic [AW-1:0] a1);
        bus.csb0 = c0; bus.web0 = w0; bus.wmask0 = m; bus.spare_wen0 = s;
        bus.addr0 = a0; bus.din0 = d; bus.csb1 = c1; bus.addr1 = a1;
        @(posedge clk0);
        expCollision = !c0 && !w0 && !c1 && (a0 == a1);
        if (!c1) expDout1 = modelMem[a1];
        if (!c0 && w0) expDout0 = modelMem[a0];
        if (!c0 && !w0) begin
            for (int i = 0; i < NM; i++)
                if (m[i]) modelMem[a0][i*MW +: MW] = d[i*MW +: MW];
            for (int j = 0; j < SC; j++)
                if (s[j]) modelMem[a0][DW+j] = d[DW+j];
        end
        @(negedge clk0);
        checkOutput("dout0", 64'(bus.dout0), 64'(expDout0));
        checkOutput("dout1", 64'(bus.dout1), 64'(expDout1));
        checkOutput("collision", 64'(bus.collision), 64'(expCollision));
        checkOutput("busy_ready", 64'(bus.busy), 64'd0);
    endtask

    // Count posedges until busy is seen low; outputs must stay quiet meanwhile.
    task automatic waitBusyDone(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(posedge clk0);
            n++;
            @(negedge clk0);
            if (n == 10) begin
                checkOutput("busy_dout0", 64'(bus.dout0), 64'd0);
                checkOutput("busy_dout1", 64'(bus.dout1), 64'd0);
                checkOutput("busy_collision", 64'(bus.collision), 64'd0);
            end
        end
    endtask

    task automatic checkAsyncReset(input string tag);
        checkOutput({tag, "_dout0"}, 64'(bus.dout0), 64'd0);
        checkOutput({tag, "_dout1"}, 64'(bus.dout1), 64'd0);
        checkOutput({tag, "_collision"}, 64'(bus.collision), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        rstb0 = 1'b0;
        rstbB = 1'b0;
        driveIdle();
        resetModel();

        repeat (3) @(negedge clk0);
        checkAsyncReset("reset");

        // Release reset while trying to write addr 7; the sweep must drop it.
        rstb0 = 1'b1;
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = '1; bus.spare_wen0 = '1;
        bus.addr0 = 6'd7; bus.din0 = '1; bus.csb1 = 1'b0; bus.addr1 = 6'd7;
        waitBusyDone(busyLen);
        checkOutput("busy_len_init", 64'(busyLen), 64'd64);
        driveIdle();

        foreach (modelMem[i]) modelMem[i] = '0;
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] a;
            a = (k == 0) ? 6'd0 : (k == 1) ? 6'd31 : (k == 2) ? 6'd63 : 6'd7;
            applyStimulus(1'b0, 1'b1, '0, '0, a, '0, 1'b0, a);
            checkOutput("init_read0", 64'(bus.dout0), 64'd0);
            checkOutput("init_read1", 64'(bus.dout1), 64'd0);
        end

        applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 6'd5, 33'h1_DEADBEEF, 1'b1, 6'd0);
        applyStimulus(1'b0, 1'b0, 4'b0101, 1'b0, 6'd5, 33'h0_11223344, 1'b1, 6'd0);
        applyStimulus(1'b0, 1'b1, '0, '0, 6'd5, '0, 1'b1, 6'd0);
        checkOutput("mask_read", 64'(bus.dout0), 64'(33'h1_DE22BE44));

        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0, 6'd9, 33'h0_AAAAAAAA, 1'b1, 6'd0);
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b0, 6'd9, 33'h0_55555555, 1'b0, 6'd9);
        checkOutput("coll_old_data", 64'(bus.dout1), 64'(33'h0_AAAAAAAA));
        checkOutput("coll_flag", 64'(bus.collision), 64'd1);
        applyStimulus(1'b1, 1'b1, '0, '0, 6'd0, '0, 1'b0, 6'd9);
        checkOutput("coll_new_data", 64'(bus.dout1), 64'(33'h0_55555555));
        checkOutput("coll_clear", 64'(bus.collision), 64'd0);

        applyStimulus(1'b0, 1'b1, '0, '0, 6'd5, '0, 1'b1, 6'd0);
        repeat (3) applyStimulus(1'b1, 1'b1, '0, '0, 6'd0, '0, 1'b1, 6'd0);
        checkOutput("hold_desel", 64'(bus.dout0), 64'(33'h1_DE22BE44));
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 6'd10, 33'h1_12345678, 1'b1, 6'd0);
        checkOutput("hold_write", 64'(bus.dout0), 64'(33'h1_DE22BE44));

        // Random traffic on a narrow address window so collisions are frequent.
        for (int it = 0; it < 400; it++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          NM'($urandom()), SC'($urandom()), AW'($urandom_range(0, 7)),
                          rnd[WW-1:0], ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)));
        end

        applyStimulus(1'b0, 1'b0, '1, '1, 6'd20, '1, 1'b1, 6'd0);
        applyStimulus(1'b0, 1'b1, '0, '0, 6'd20, '0, 1'b0, 6'd20);
        #2 rstb0 = 1'b0;
        #1 checkAsyncReset("async_ready");
        resetModel();
        repeat (2) @(negedge clk0);
        rstb0 = 1'b1;
        repeat (20) @(posedge clk0);
        #2 rstb0 = 1'b0;
        #1 checkAsyncReset("async_sweep");
        repeat (2) @(negedge clk0);
        rstb0 = 1'b1;
        waitBusyDone(busyLen);
        checkOutput("busy_len_restart", 64'(busyLen), 64'd64);
        applyStimulus(1'b0, 1'b1, '0, '0, 6'd20, '0, 1'b0, 6'd63);

        checkOutput("noinit_busy_rst", 64'(busB.busy), 64'd0);
        rstbB = 1'b1;
        busB.csb0 = 1'b0; busB.web0 = 1'b0; busB.wmask0 = '1; busB.spare_wen0 = '1;
        busB.addr0 = 6'd63; busB.din0 = 33'h1_CAFEF00D;
        checkOutput("noinit_busy_rel", 64'(busB.busy), 64'd0);
        @(negedge clk0);
        checkOutput("noinit_busy_run", 64'(busB.busy), 64'd0);
        busB.web0 = 1'b1; busB.csb1 = 1'b0; busB.addr1 = 6'd63;
        @(negedge clk0);
        checkOutput("noinit_dout0", 64'(busB.dout0), 64'(33'h1_CAFEF00D));
        checkOutput("noinit_dout1", 64'(busB.dout1), 64'(33'h1_CAFEF00D));
        checkOutput("noinit_collision", 64'(busB.collision), 64'd0);
        driveIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/sram_1rw1r_param_model.md
Name: sram_1rw1r_param_model

Overview:
Parametrised single-clock SRAM model with one read/write port (port 0) and one read-only port (port 1).
- Adds byte/word write-mask granularity, configurable spare columns and a reset-driven initialisation sweep.
- Flags read/write collisions between the two ports.
- Fully synchronous, posedge only, no # delays; usable for simulation and as a flop-based fallback macro in the testchip.

Parameters:
DATA_WIDTH, 32, data bits per word excluding spare columns; must be a multiple of WMASK_WIDTH
WMASK_WIDTH, 8, bits per write-mask lane
NUM_WMASKS, DATA_WIDTH/WMASK_WIDTH, number of mask lanes (derived)
NUM_SPARE_COLS, 1, spare columns per word (>=1), each with its own write enable
ADDR_WIDTH, 6, address bits; RAM_DEPTH = 1<<ADDR_WIDTH
WORD_WIDTH, DATA_WIDTH+NUM_SPARE_COLS, stored word width (derived)
INIT_ON_RESET, 1, 1 = sweep INIT_VALUE into every word after reset; 0 = skip the sweep
INIT_VALUE, 0, WORD_WIDTH-bit value written by the sweep

Ports:
clk0  input  1  clock; all state changes on posedge
rstb0  input  1  asynchronous active-low reset
csb0  input  1  port 0 chip select, active low
web0  input  1  port 0 write enable, active low (1 = read)
wmask0  input  NUM_WMASKS  per-lane write enable, bit i covers din0[i*WMASK_WIDTH +: WMASK_WIDTH]
spare_wen0  input  NUM_SPARE_COLS  write enable for spare bit DATA_WIDTH+i
addr0  input  ADDR_WIDTH  port 0 address
din0  input  WORD_WIDTH  port 0 write data
dout0  output  WORD_WIDTH  port 0 read data
csb1  input  1  port 1 chip select, active low (read only)
addr1  input  ADDR_WIDTH  port 1 address
dout1  output  WORD_WIDTH  port 1 read data
busy  output  1  high while the init sweep runs; both ports are ignored
collision  output  1  one-cycle pulse on a port 1 read of the address port 0 is writing

Behaviour:
- Reset (rstb0 low, async): dout0, dout1, collision = 0; busy = INIT_ON_RESET; FSM to INIT (or READY if INIT_ON_RESET=0); sweep counter = 0.
- Array contents are not reset except through the sweep.
- FSM states:
  - INIT: each posedge writes INIT_VALUE to mem[cnt]; cnt increments.
  - INIT to READY on the edge that writes address RAM_DEPTH-1; busy falls with that edge.
  - busy is high for exactly RAM_DEPTH posedges after rstb0 rises.
  - READY: normal operation.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release.
- While busy: csb0/csb1 ignored, no user writes, dout0/dout1 hold 0, collision = 0.
- Port 0 write (READY, csb0=0, web0=0, sampled at posedge E):
  - Only lanes with wmask0[i]=1 and spare bits with spare_wen0[j]=1 update at E.
  - Unmasked bits keep their old value.
  - dout0 holds its previous value.
  - wmask0=0 and spare_wen0=0 together is a legal no-op.
- Port 0 read (csb0=0, web0=1): dout0 = mem[addr0] registered at E, visible after E (latency 1).
- Port 1 read (csb1=0): dout1 = mem[addr1] registered at E, latency 1.
- Deselected port (csb=1): its dout holds its last value. Never X; never cleared except by reset.
- Same-edge port 0 write and port 1 read of the same address:
  - dout1 returns the pre-write (old) contents.
  - collision = 1 for the cycle after E.
  - The write completes normally.
  - Different addresses, or port 0 reading: collision = 0.
- Both ports reading the same address: both return the same data, no collision.
- Address wrap: addr is exactly ADDR_WIDTH bits; there is no out-of-range case.
- Sweep counter width is ADDR_WIDTH+1 or equivalent terminal detect; it must not wrap back into INIT.

Test Plan:
- Init sweep, defaults: release rstb0 -> busy high for exactly 64 posedges; then reading addr 0, 31 and 63 on both ports returns 33'h0. Port 0 writes issued during busy are dropped (readback still 0).
- Masked write: write 33'h1_DEADBEEF to addr 5 with wmask0=4'hF and spare_wen0=1; then write 33'h0_11223344 with wmask0=4'b0101 and spare_wen0=0 -> read addr 5 gives 33'h1_DE22BE44, one cycle after the read edge.
- Collision: addr 9 holds 33'h0_AAAAAAAA; port 0 writes 33'h0_55555555 (full mask) to addr 9 on the same edge port 1 reads addr 9 -> dout1 = 33'h0_AAAAAAAA and collision = 1 for one cycle. The next port 1 read gives 33'h0_55555555 and collision = 0.
- Hold behaviour: read addr 5 on port 0, then three cycles with csb0=1 -> dout0 stays 33'h1_DE22BE44. A following port 0 write leaves dout0 unchanged.
- Reset mid-sweep: pull rstb0 low at sweep cycle 20 for 2 cycles -> dout0/dout1/collision = 0 immediately (async). After release busy lasts 64 full cycles.
- INIT_ON_RESET=0 build: busy never asserts. A write and readback to addr 63 works on the first cycle after reset release.
